// File: rtl/fifo_pkg.sv
// Shared types and helpers for the FIFO write-side arbiter.
package fifo_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    GRANT0   = 3'd1,
    GRANT1   = 3'd2,
    CLEAR    = 3'd3,
    CLR_WAIT = 3'd4
  } arb_state_t;

  localparam int unsigned NUM_REQ = 2;

  // Width of the FIFO fill-level bus for a given depth.
  function automatic int unsigned addr_w(input int unsigned depth);
    return $clog2(depth - 1);
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Two-input round-robin selector: the preferred requester wins a tie.
module rr_pick
  import fifo_pkg::*;
(
  input  logic [NUM_REQ-1:0] valid,
  input  logic               prio,
  output logic [NUM_REQ-1:0] pick
);

  // One-hot pick of the preferred valid requester, else the other one.
  always_comb begin
    pick = '0;
    if (valid[prio]) begin
      pick[prio] = 1'b1;
    end else if (valid[~prio]) begin
      pick[~prio] = 1'b1;
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst-locked write arbiter in front of a synchronous FIFO,
// with clear sequencing. Write-side outputs are combinational from state.
module fifo_wr_arbiter
  import fifo_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned DEPTH     = 32,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic                       CLOCK,
  input  logic                       RESET,
  input  logic                       REQ0_VALID,
  input  logic [WIDTH-1:0]           REQ0_DATA,
  input  logic                       REQ0_LAST,
  output logic                       REQ0_READY,
  input  logic                       REQ1_VALID,
  input  logic [WIDTH-1:0]           REQ1_DATA,
  input  logic                       REQ1_LAST,
  output logic                       REQ1_READY,
  input  logic                       CLR_REQ,
  output logic                       CLR_BUSY,
  output logic [NUM_REQ-1:0]         GRANT,
  output logic                       WRITE,
  output logic [WIDTH-1:0]           DATA_IN,
  output logic                       CLEAR_N,
  input  logic                       F_FULL_N,
  input  logic                       F_EMPTY_N,
  input  logic [addr_w(DEPTH)-1:0]   USE_DW
);

  localparam int unsigned BCNT_W     = 4;
  localparam logic [BCNT_W-1:0] BURST_LAST = BCNT_W'(MAX_BURST - 1);

  arb_state_t          state_q, state_d;
  logic [BCNT_W-1:0]   bcnt_q, bcnt_d;
  logic                prio_q, prio_d;
  logic                clr_pend_q, clr_pend_d;

  logic [NUM_REQ-1:0]  pick;
  logic                in_grant;
  logic                cur_valid;
  logic                cur_last;
  logic [WIDTH-1:0]    cur_data;
  logic                xfer;
  logic                burst_end;

  // Fill level is observed only; it never steers arbitration.
  logic                unused_use_dw;
  assign unused_use_dw = ^USE_DW;

  rr_pick u_rr_pick (
    .valid (({REQ1_VALID, REQ0_VALID})),
    .prio  (prio_q),
    .pick  (pick)
  );

  // Owner-side view of the handshake and the write-port outputs.
  always_comb begin
    in_grant   = (state_q == GRANT0) || (state_q == GRANT1);
    cur_valid  = (state_q == GRANT1) ? REQ1_VALID : REQ0_VALID;
    cur_last   = (state_q == GRANT1) ? REQ1_LAST  : REQ0_LAST;
    cur_data   = (state_q == GRANT1) ? REQ1_DATA  : REQ0_DATA;
    xfer       = in_grant && cur_valid && F_FULL_N;
    burst_end  = xfer && (cur_last || (bcnt_q == BURST_LAST));

    GRANT      = {state_q == GRANT1, state_q == GRANT0};
    REQ0_READY = (state_q == GRANT0) && F_FULL_N;
    REQ1_READY = (state_q == GRANT1) && F_FULL_N;
    WRITE      = xfer;
    DATA_IN    = xfer ? cur_data : '0;
    CLEAR_N    = (state_q != CLEAR);
    CLR_BUSY   = clr_pend_q || (state_q == CLEAR) || (state_q == CLR_WAIT);
  end

  // Next-state logic; a new clear request wins over the consume on CLEAR entry.
  always_comb begin
    state_d    = state_q;
    bcnt_d     = bcnt_q;
    prio_d     = prio_q;
    clr_pend_d = clr_pend_q || CLR_REQ;

    case (state_q)
      IDLE: begin
        if (clr_pend_q) begin
          state_d    = CLEAR;
          clr_pend_d = CLR_REQ;
        end else if (pick[0]) begin
          state_d = GRANT0;
        end else if (pick[1]) begin
          state_d = GRANT1;
        end
      end
      GRANT0, GRANT1: begin
        if (xfer) begin
          bcnt_d = bcnt_q + BCNT_W'(1);
        end
        if (burst_end) begin
          state_d = IDLE;
          bcnt_d  = '0;
          prio_d  = (state_q == GRANT0);
        end
      end
      CLEAR: begin
        state_d = CLR_WAIT;
      end
      CLR_WAIT: begin
        if (!F_EMPTY_N) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state_q    <= IDLE;
      bcnt_q     <= '0;
      prio_q     <= 1'b0;
      clr_pend_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      bcnt_q     <= bcnt_d;
      prio_q     <= prio_d;
      clr_pend_q <= clr_pend_d;
    end
  end

endmodule
